// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin share of one AXI4 read channel (AR + R) among
// NUM_REQ requesters. The winning AR is registered with the requester index
// prefixed onto ARID; R beats are steered back by those upper ID bits.
// Per-requester outstanding-burst counters throttle eligibility.

// Outstanding-burst counter for one requester.
module axi_rd_arb_cnt #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          udf
);
  logic down;

  // A last beat for a requester with nothing outstanding is an underflow.
  assign udf  = dec && (cnt == '0);
  assign down = dec && !udf;

  // Count grants up and completed bursts down; both at once cancel out.
  always_ff @(posedge clk) begin
    if (rst)                cnt <= '0;
    else if (inc && !down)  cnt <= cnt + CW'(1);
    else if (!inc && down)  cnt <= cnt - CW'(1);
  end
endmodule

module axi_rd_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int IDW      = 4,
  parameter int MAX_OUTS = 4,
  localparam int IXW  = $clog2(NUM_REQ),
  localparam int LIDW = IDW - IXW,
  localparam int CW   = $clog2(MAX_OUTS + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_REQ-1:0]      s_arvalid_i,
  output logic [NUM_REQ-1:0]      s_arready_o,
  input  logic [NUM_REQ*AW-1:0]   s_araddr_i,
  input  logic [NUM_REQ*LIDW-1:0] s_arid_i,
  input  logic [NUM_REQ*8-1:0]    s_arlen_i,
  input  logic [NUM_REQ*3-1:0]    s_arsize_i,
  input  logic [NUM_REQ*2-1:0]    s_arburst_i,
  output logic [NUM_REQ-1:0]      s_rvalid_o,
  input  logic [NUM_REQ-1:0]      s_rready_i,
  output logic [LIDW-1:0]         s_rid_o,
  output logic [DW-1:0]           s_rdata_o,
  output logic [1:0]              s_rresp_o,
  output logic                    s_rlast_o,
  output logic                    m_arvalid_o,
  input  logic                    m_arready_i,
  output logic [AW-1:0]           m_araddr_o,
  output logic [IDW-1:0]          m_arid_o,
  output logic [7:0]              m_arlen_o,
  output logic [2:0]              m_arsize_o,
  output logic [1:0]              m_arburst_o,
  output logic                    m_arlock_o,
  output logic [2:0]              m_arprot_o,
  output logic [3:0]              m_arcache_o,
  input  logic                    m_rvalid_i,
  output logic                    m_rready_o,
  input  logic [IDW-1:0]          m_rid_i,
  input  logic [DW-1:0]           m_rdata_i,
  input  logic [1:0]              m_rresp_i,
  input  logic                    m_rlast_i,
  output logic                    err_o
);
  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [LIDW-1:0] id;
    logic [7:0]      len;
    logic [2:0]      size;
    logic [1:0]      burst;
  } ar_req_t;

  ar_req_t [NUM_REQ-1:0]          s_req;
  ar_req_t                        m_req;
  logic    [IXW-1:0]              m_ix;
  logic    [IXW-1:0]              rr_ptr;
  logic    [IXW-1:0]              win;
  logic    [IXW-1:0]              cand;
  logic                           found;
  logic                           load;
  logic    [NUM_REQ-1:0]          elig;
  logic    [NUM_REQ-1:0]          inc;
  logic    [NUM_REQ-1:0]          dec;
  logic    [NUM_REQ-1:0]          udf;
  logic    [NUM_REQ-1:0][CW-1:0]  cnt;
  logic    [IXW-1:0]              r_idx;
  logic                           r_done;

  // Per-requester unpacking, eligibility and outstanding counters.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign s_req[g].addr  = s_araddr_i[g*AW +: AW];
    assign s_req[g].id    = s_arid_i[g*LIDW +: LIDW];
    assign s_req[g].len   = s_arlen_i[g*8 +: 8];
    assign s_req[g].size  = s_arsize_i[g*3 +: 3];
    assign s_req[g].burst = s_arburst_i[g*2 +: 2];
    assign elig[g] = s_arvalid_i[g] && (cnt[g] < CW'(MAX_OUTS));
    assign inc[g]  = load && (win == IXW'(g));
    assign dec[g]  = r_done && (r_idx == IXW'(g));

    axi_rd_arb_cnt #(.CW(CW)) u_cnt (
      .clk (clk_i),
      .rst (rst_i),
      .inc (inc[g]),
      .dec (dec[g]),
      .cnt (cnt[g]),
      .udf (udf[g])
    );
  end

  // Pick the first eligible requester at or after rr_ptr (wraps naturally).
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = rr_ptr + IXW'(k);
      if (!found && elig[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  assign load        = !rst_i && found && (!m_arvalid_o || m_arready_i);
  assign s_arready_o = load ? (NUM_REQ'(1) << win) : '0;

  // AR output register: reload whenever free (or draining) and someone wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_arvalid_o <= 1'b0;
      m_req       <= '0;
      m_ix        <= '0;
      rr_ptr      <= '0;
    end else if (load) begin
      m_arvalid_o <= 1'b1;
      m_req       <= s_req[win];
      m_ix        <= win;
      rr_ptr      <= win + IXW'(1);
    end else if (m_arready_i) begin
      m_arvalid_o <= 1'b0;
    end
  end

  assign m_araddr_o  = m_req.addr;
  assign m_arid_o    = {m_ix, m_req.id};
  assign m_arlen_o   = m_req.len;
  assign m_arsize_o  = m_req.size;
  assign m_arburst_o = m_req.burst;
  assign m_arlock_o  = 1'b0;
  assign m_arprot_o  = 3'd1;
  assign m_arcache_o = 4'd15;

  // R path is pure steering on the upper ID bits; nothing is buffered.
  assign r_idx      = m_rid_i[IDW-1 -: IXW];
  assign s_rvalid_o = m_rvalid_i ? (NUM_REQ'(1) << r_idx) : '0;
  assign m_rready_o = s_rready_i[r_idx];
  assign s_rid_o    = m_rid_i[LIDW-1:0];
  assign s_rdata_o  = m_rdata_i;
  assign s_rresp_o  = m_rresp_i;
  assign s_rlast_o  = m_rlast_i;
  assign r_done     = m_rvalid_i && m_rready_o && m_rlast_i;

  // Sticky error: a burst completed that was never granted.
  always_ff @(posedge clk_i) begin
    if (rst_i)     err_o <= 1'b0;
    else if (|udf) err_o <= 1'b1;
  end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_axi_rd_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   s_arvalid, s_arready, s_rvalid, s_rready;
  logic [127:0] s_araddr;
  logic [7:0]   s_arid;
  logic [31:0]  s_arlen;
  logic [11:0]  s_arsize;
  logic [7:0]   s_arburst;
  logic [1:0]   s_rid, s_rresp, m_arburst, m_rresp;
  logic [31:0]  s_rdata, m_araddr, m_rdata;
  logic         s_rlast, m_arvalid, m_arready, m_arlock, m_rvalid, m_rready, m_rlast, err;
  logic [3:0]   m_arid, m_arcache, m_rid;
  logic [7:0]   m_arlen;
  logic [2:0]   m_arsize, m_arprot;

  int nchk = 0;
  int nfail = 0;

  axi_rd_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .s_arvalid_i(s_arvalid), .s_arready_o(s_arready), .s_araddr_i(s_araddr),
    .s_arid_i(s_arid), .s_arlen_i(s_arlen), .s_arsize_i(s_arsize), .s_arburst_i(s_arburst),
    .s_rvalid_o(s_rvalid), .s_rready_i(s_rready), .s_rid_o(s_rid), .s_rdata_o(s_rdata),
    .s_rresp_o(s_rresp), .s_rlast_o(s_rlast),
    .m_arvalid_o(m_arvalid), .m_arready_i(m_arready), .m_araddr_o(m_araddr), .m_arid_o(m_arid),
    .m_arlen_o(m_arlen), .m_arsize_o(m_arsize), .m_arburst_o(m_arburst),
    .m_arlock_o(m_arlock), .m_arprot_o(m_arprot), .m_arcache_o(m_arcache),
    .m_rvalid_i(m_rvalid), .m_rready_o(m_rready), .m_rid_i(m_rid), .m_rdata_i(m_rdata),
    .m_rresp_i(m_rresp), .m_rlast_i(m_rlast), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Model state: what the bus-side register and counters must hold.
  bit         mv = 0;
  logic [31:0] maddr = '0;
  logic [3:0]  mid = '0;
  logic [7:0]  mlen = '0;
  logic [2:0]  msize = '0;
  logic [1:0]  mburst = '0;
  int          mrr = 0;
  int          mcnt[4] = '{0, 0, 0, 0};
  bit          merr = 0;
  logic [3:0]  gl = '0;
  logic [3:0]  oneshot = '0;

  // Compare all outputs against the model, then advance it past the next edge.
  always @(negedge clk) begin : model
    int w, ridx;
    bit found, ld, hs;
    logic [3:0] e_ard, e_rv;
    found = 0;
    w = 0;
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (mrr + k) % 4;
      if (!found && s_arvalid[j] && mcnt[j] < 4) begin
        found = 1;
        w = j;
      end
    end
    ld    = !rst && found && (!mv || m_arready);
    e_ard = ld ? (4'b0001 << w) : 4'b0000;
    ridx  = int'(m_rid) / 4;
    e_rv  = m_rvalid ? (4'b0001 << ridx) : 4'b0000;
    hs    = m_rvalid && s_rready[ridx] && m_rlast;

    chk("s_arready", s_arready, e_ard);
    chk("s_rvalid", s_rvalid, e_rv);
    chk("m_rready", m_rready, s_rready[ridx]);
    chk("s_rid", s_rid, int'(m_rid) % 4);
    chk("s_rdata", s_rdata, m_rdata);
    chk("s_rresp", s_rresp, m_rresp);
    chk("s_rlast", s_rlast, m_rlast);
    chk("m_arvalid", m_arvalid, mv);
    chk("m_araddr", m_araddr, maddr);
    chk("m_arid", m_arid, mid);
    chk("m_arlen", m_arlen, mlen);
    chk("m_arsize", m_arsize, msize);
    chk("m_arburst", m_arburst, mburst);
    chk("attrs", {m_arlock, m_arprot, m_arcache}, {1'b0, 3'd1, 4'd15});
    chk("err", err, merr);
    gl = e_ard;

    if (rst) begin
      mv = 0; maddr = '0; mid = '0; mlen = '0; msize = '0; mburst = '0;
      mrr = 0; merr = 0;
      for (int k = 0; k < 4; k++) mcnt[k] = 0;
    end else begin
      if (hs) begin
        if (mcnt[ridx] == 0) merr = 1;
        else mcnt[ridx]--;
      end
      if (ld) begin
        mcnt[w]++;
        mv     = 1;
        maddr  = s_araddr[w*32 +: 32];
        mid    = 4'(w * 4 + int'(s_arid[w*2 +: 2]));
        mlen   = s_arlen[w*8 +: 8];
        msize  = s_arsize[w*3 +: 3];
        mburst = s_arburst[w*2 +: 2];
        mrr    = (w + 1) % 4;
      end else if (m_arready) begin
        mv = 0;
      end
    end
  end

  // Advance one cycle; one-shot requesters drop valid once granted.
  task automatic tick();
    @(posedge clk);
    #1;
    s_arvalid = s_arvalid & ~(gl & oneshot);
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [1:0] id, input logic [7:0] len);
    s_araddr[i*32 +: 32] = a;
    s_arid[i*2 +: 2]     = id;
    s_arlen[i*8 +: 8]    = len;
    s_arsize[i*3 +: 3]   = 3'd2;
    s_arburst[i*2 +: 2]  = 2'd1;
    s_arvalid[i]         = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    s_arvalid = '0; s_araddr = '0; s_arid = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
    s_rready = 4'hF; m_arready = 1'b1;
    m_rvalid = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_arvalid", m_arvalid, 1'b0);
    chk("rst_araddr", m_araddr, 32'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_attrs", {m_arlock, m_arprot, m_arcache}, 8'b0_001_1111);

    // Single requester: req2, addr 0x1000, id 1, len 3.
    oneshot = 4'hF;
    set_req(2, 32'h1000, 2'd1, 8'd3);
    #1 chk("t1_grant", s_arready, 4'b0100);
    tick();
    #1;
    chk("t1_arvalid", m_arvalid, 1'b1);
    chk("t1_arid", m_arid, 4'b1001);
    chk("t1_araddr", m_araddr, 32'h1000);
    chk("t1_arlen", m_arlen, 8'd3);
    chk("t1_model_cnt1", mcnt[2], 1);
    tick();
    #1 chk("t1_accepted", m_arvalid, 1'b0);
    for (int b = 0; b < 4; b++) begin
      m_rvalid = 1'b1; m_rid = 4'h9; m_rdata = 32'hA000 + b; m_rlast = (b == 3);
      #1;
      chk("t1_rvalid", s_rvalid, 4'b0100);
      chk("t1_rid", s_rid, 2'd1);
      tick();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    chk("t1_model_cnt0", mcnt[2], 0);
    chk("t1_err", err, 1'b0);

    // Round-robin with all four requesters continuously valid.
    do_reset();
    oneshot = 4'h0;
    for (int i = 0; i < 4; i++) set_req(i, 32'h100 * i, 2'(i), 8'd0);
    for (int k = 0; k < 8; k++) begin
      #1 chk("rr_order", s_arready, 4'b0001 << (k % 4));
      if (k > 0) chk("rr_no_bubble", m_arvalid, 1'b1);
      tick();
    end
    s_arvalid = '0;
    tick();

    // Backpressure: register holds for 5 cycles, then req1 loads.
    do_reset();
    m_arready = 1'b0;
    oneshot = 4'b0011;
    set_req(0, 32'h2000, 2'd0, 8'd1);
    set_req(1, 32'h3000, 2'd2, 8'd1);
    #1 chk("bp_first", s_arready, 4'b0001);
    tick();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_no_grant", s_arready, 4'b0000);
      chk("bp_hold_addr", m_araddr, 32'h2000);
      chk("bp_hold_valid", m_arvalid, 1'b1);
      tick();
    end
    m_arready = 1'b1;
    #1 chk("bp_reload_grant", s_arready, 4'b0010);
    tick();
    #1;
    chk("bp_reload_addr", m_araddr, 32'h3000);
    chk("bp_reload_id", m_arid, 4'b0110);
    tick();
    #1 chk("bp_drain", m_arvalid, 1'b0);

    // Outstanding limit on req0, then completion and simultaneous inc/dec.
    do_reset();
    oneshot = 4'h0;
    set_req(0, 32'h4000, 2'd0, 8'd0);
    for (int k = 0; k < 4; k++) tick();
    #1;
    chk("lim_stall", s_arready, 4'b0000);
    chk("lim_model_cnt", mcnt[0], 4);
    oneshot = 4'b0010;
    set_req(1, 32'h5000, 2'd3, 8'd0);
    #1 chk("lim_req1", s_arready, 4'b0010);
    tick();
    m_rvalid = 1'b1; m_rid = 4'h0; m_rlast = 1'b1;
    #1;
    chk("lim_still_full", s_arready, 4'b0000);
    chk("lim_rvalid", s_rvalid, 4'b0001);
    tick();
    #1 chk("lim_resume", s_arready, 4'b0001);
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    chk("sim_model_cnt", mcnt[0], 3);
    chk("sim_eligible", s_arready, 4'b0001);
    tick();
    s_arvalid = '0;
    tick();

    // R beat for a requester with nothing outstanding: sticky error.
    m_rvalid = 1'b1; m_rid = 4'b1100; m_rlast = 1'b1;
    #1;
    chk("err_rvalid", s_rvalid, 4'b1000);
    chk("err_rready", m_rready, 1'b1);
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1 chk("err_set", err, 1'b1);
    for (int k = 0; k < 3; k++) tick();
    #1 chk("err_sticky", err, 1'b1);

    // Reset while the AR register is full.
    m_arready = 1'b0;
    oneshot = 4'b0010;
    set_req(1, 32'h6000, 2'd1, 8'd0);
    tick();
    #1 chk("rm_loaded", m_arvalid, 1'b1);
    oneshot = 4'h0;
    for (int i = 0; i < 4; i++) set_req(i, 32'h7000 + 32'h10 * i, 2'd0, 8'd0);
    do_reset();
    m_arready = 1'b1;
    #1;
    chk("rm_arvalid", m_arvalid, 1'b0);
    chk("rm_err_clear", err, 1'b0);
    chk("rm_model_cnt", mcnt[0] + mcnt[1] + mcnt[2] + mcnt[3], 0);
    chk("rm_rr_ptr", s_arready, 4'b0001);
    tick();
    s_arvalid = '0;
    m_rvalid = 1'b1; m_rid = 4'h4; m_rlast = 1'b1;
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1 chk("rm_inflight_err", err, 1'b1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Round-robin arbiter that shares one AXI4 read channel (AR + R) of width BUS_AW=32 / BUS_DW=32 / BUS_IDW=4 among NUM_REQ read requesters. It registers the winning AR request and prefixes the requester index onto ARID. Returning R beats are steered back to the right requester by the upper ID bits. Per-requester outstanding-burst counters throttle requesters. ARLOCK/ARPROT/ARCACHE are driven with the team's fixed read attributes 0 / 1 / 15.

## Interface
- NUM_REQ, 4, number of requesters; power of two, 2..4
- AW, 32, address width (BUS_AW)
- DW, 32, data width (BUS_DW)
- IDW, 4, bus ID width (BUS_IDW)
- MAX_OUTS, 4, maximum outstanding bursts per requester, ≥1
- Derived: IXW = clog2(NUM_REQ); LIDW = IDW-IXW (local ID width); CW = clog2(MAX_OUTS+1)
- Clock and reset: one clock; reset is synchronous and active-high.
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- s_arvalid_i  in  NUM_REQ  per-requester AR valid
- s_arready_o  out  NUM_REQ  per-requester AR accept
- s_araddr_i  in  NUM_REQ*AW  packed addresses, requester i at [i*AW +: AW]
- s_arid_i  in  NUM_REQ*LIDW  packed local IDs
- s_arlen_i / s_arsize_i / s_arburst_i  in  NUM_REQ*8 / NUM_REQ*3 / NUM_REQ*2  packed burst fields
- s_rvalid_o  out  NUM_REQ  per-requester R valid
- s_rready_i  in  NUM_REQ  per-requester R ready
- s_rid_o  out  LIDW  local ID, shared to all requesters
- s_rdata_o / s_rresp_o / s_rlast_o  out  DW / 2 / 1  shared R payload
- m_arvalid_o / m_arready_i  out / in  1 / 1  bus AR handshake
- m_araddr_o / m_arid_o / m_arlen_o / m_arsize_o / m_arburst_o  out  AW / IDW / 8 / 3 / 2  registered AR payload
- m_arlock_o / m_arprot_o / m_arcache_o  out  1 / 3 / 4  constants 0, 1, 15
- m_rvalid_i / m_rready_o  in / out  1 / 1  bus R handshake
- m_rid_i / m_rdata_i / m_rresp_i / m_rlast_i  in  IDW / DW / 2 / 1  bus R payload
- err_o  out  1  sticky: R beat received with no outstanding burst for its requester

## Operation
- Eligibility: requester i is eligible when s_arvalid_i[i]=1 and cnt[i] < MAX_OUTS.
- Output register: loads when (!m_arvalid_o || m_arready_i) and at least one requester is eligible.
- Winner selection: first eligible requester at or after rr_ptr, modulo NUM_REQ.
- In the load cycle:
  - s_arready_o[winner] = 1 and all other s_arready_o bits = 0 (one-hot or zero).
  - Payload is captured; m_arid_o = {winner, s_arid local}.
  - rr_ptr <= winner+1, wrapping at NUM_REQ.
  - cnt[winner] increments.
- Holding: m_arvalid_o stays 1 with stable payload until m_arready_i=1. When m_arready_i=1 and a new winner exists in the same cycle, the register reloads back-to-back.
- R routing (combinational):
  - idx = m_rid_i[IDW-1 -: IXW].
  - s_rvalid_o[idx] = m_rvalid_i; all other bits 0.
  - m_rready_o = s_rready_i[idx].
  - s_rid_o = m_rid_i[LIDW-1:0].
  - rdata/rresp/rlast are passed straight through.
- Counters:
  - Decrement on an R handshake with rlast=1 for idx.
  - Simultaneous increment and decrement on the same requester leaves the count unchanged.
  - A decrement when cnt[idx]=0 leaves the count at 0 and sets err_o.
- Attribute outputs are constant: m_arlock_o=0, m_arprot_o=3'd1, m_arcache_o=4'd15.

## Timing
- Reset values: m_arvalid_o=0, all m_ar* payload=0, rr_ptr=0, all cnt=0, err_o=0. s_arready_o=0 while rst_i=1.
- AR latency: requester handshake in cycle N gives m_arvalid_o=1 in N+1.
- AR throughput: one burst per cycle while m_arready_i stays high.
- R path latency: zero cycles, with no R buffering.
- Reset asserted mid-burst:
  - m_arvalid_o drops the next cycle.
  - Counters clear; in-flight R beats after reset do set err_o.
  - rr_ptr returns to 0.
- Requester i must keep s_arvalid_i and its payload stable until s_arready_o[i]=1. The arbiter never revokes a grant.

## Test plan
- Single requester: req2 sends addr 0x1000, id 1, len 3 → m_arvalid_o=1 one cycle later, m_arid_o=4'b1001, prot=1, cache=15, lock=0; 4 R beats with rid 9 reach s_rvalid_o[2] only; cnt[2] goes 1 then 0.
- Round-robin: all 4 requesters valid continuously, m_arready_i=1 → grant order 0,1,2,3,0,…; back-to-back m_arvalid_o with no bubble.
- Backpressure: m_arready_i=0 for 5 cycles → payload stable, no s_arready_o pulses; the next winner loads in the cycle m_arready_i returns to 1.
- Outstanding limit: req0 issues 4 bursts with no R traffic → 5th request stalls and req1 is served; one rlast to req0 → req0 is eligible in the next arbitration.
- Simultaneous events and errors: capture and rlast for the same requester in one cycle → count unchanged. R beat with rid 4'b1100 while cnt[3]=0 → err_o=1 and stays 1 until reset.
- Reset mid-operation: rst_i pulsed while m_arvalid_o=1 → next cycle m_arvalid_o=0, counters 0, rr_ptr=0.
